// File: rtl/sound_player.sv
// sound_player: sequences per-effect melodies from a note ROM into a muteable square-wave speaker output
module sound_player #(
  parameter int NOTE_LEN     = 2_500_000,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_sound
);
  localparam int DW = $clog2(NOTE_LEN);
  localparam logic [DW-1:0] DUR_MAX = DW'(NOTE_LEN - 1);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [1:0] note_idx, note_idx_n, cur_n;
  logic [15:0] hp_cnt, hp_cnt_n, hp;
  logic [DW-1:0] dur_cnt, dur_cnt_n;
  logic spk, spk_n, done_n;
  logic [1:0] last_idx;
  function automatic logic [15:0] rom(input logic [1:0] s, input logic [1:0] i);
    case ({s, i})
      4'b00_00: rom = 16'd18432;
      4'b01_00: rom = 16'd24576;
      4'b01_01: rom = 16'd19456;
      4'b01_10: rom = 16'd16384;
      4'b10_00: rom = 16'd32768;
      4'b10_01: rom = 16'd36864;
      4'b10_10: rom = 16'd45056;
      4'b10_11: rom = 16'd61440;
      4'b11_00: rom = 16'd24576;
      4'b11_01: rom = 16'd19456;
      4'b11_10: rom = 16'd16384;
      4'b11_11: rom = 16'd12288;
      default:  rom = 16'd0;
    endcase
  endfunction
  assign hp = rom(cur_sound, note_idx) >> PERIOD_SHIFT;
  assign last_idx = cur_sound == 2'd0 ? 2'd0 : cur_sound == 2'd1 ? 2'd2 : 2'd3;
  always_comb begin
    state_n = state;
    note_idx_n = note_idx;
    hp_cnt_n = hp_cnt;
    dur_cnt_n = dur_cnt;
    spk_n = spk;
    cur_n = cur_sound;
    done_n = 1'b0;
    if (playsound) begin
      state_n = PLAY;
      cur_n = soundselector;
      note_idx_n = 2'd0;
      hp_cnt_n = 16'd0;
      dur_cnt_n = '0;
      spk_n = 1'b0;
    end else if (state == PLAY) begin
      // a zero half-period is a rest: hold the speaker low
      if (hp == 16'd0) begin
        hp_cnt_n = 16'd0;
        spk_n = 1'b0;
      end else if (hp_cnt == hp - 16'd1) begin
        hp_cnt_n = 16'd0;
        spk_n = ~spk;
      end else hp_cnt_n = hp_cnt + 16'd1;
      if (dur_cnt == DUR_MAX) begin
        dur_cnt_n = '0;
        hp_cnt_n = 16'd0;
        spk_n = 1'b0;
        if (note_idx == last_idx) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else note_idx_n = note_idx + 2'd1;
      end else dur_cnt_n = dur_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      note_idx <= 2'd0;
      hp_cnt <= 16'd0;
      dur_cnt <= '0;
      spk <= 1'b0;
      done <= 1'b0;
      cur_sound <= 2'd0;
    end else begin
      state <= state_n;
      note_idx <= note_idx_n;
      hp_cnt <= hp_cnt_n;
      dur_cnt <= dur_cnt_n;
      spk <= spk_n;
      done <= done_n;
      cur_sound <= cur_n;
    end
  end
  assign busy = state == PLAY;
  assign speaker = spk & ~mute;
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed and random stimulus checked against a time-since-start melody model
module tb_sound_player;
  logic clk = 1'b0, reset = 1'b0, playsound = 1'b0, mute = 1'b0;
  logic [1:0] soundselector = 2'd0;
  logic speaker, busy, done;
  logic [1:0] cur_sound;
  int total = 0, bad = 0;
  int m_act = 0, m_t = 0, m_cur = 0, m_done = 0;
  int busy_n = 0, done_n = 0;
  int notes[4][4] = '{'{18432, 0, 0, 0}, '{24576, 19456, 16384, 0},
                      '{32768, 36864, 45056, 61440}, '{24576, 19456, 16384, 12288}};
  int lens[4] = '{1, 3, 4, 4};

  sound_player #(.NOTE_LEN(64), .PERIOD_SHIFT(10)) dut (
    .clk(clk), .reset(reset), .playsound(playsound), .soundselector(soundselector),
    .mute(mute), .speaker(speaker), .busy(busy), .done(done), .cur_sound(cur_sound)
  );

  always #5 clk = ~clk;

  function automatic int tone(int s, int t);
    int hp = notes[s][t / 64] >> 10;
    int k = t % 64;
    return hp == 0 ? 0 : (k / hp) % 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, m_t, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ps, input int sel, input logic m);
    reset = r;
    playsound = ps;
    soundselector = 2'(sel);
    mute = m;
    @(posedge clk);
    #1;
    m_done = 0;
    if (!r) begin
      m_act = 0; m_t = 0; m_cur = 0;
    end else if (ps) begin
      m_act = 1; m_t = 0; m_cur = sel;
    end else if (m_act != 0) begin
      m_t++;
      if (m_t == lens[m_cur] * 64) begin
        m_act = 0; m_done = 1;
      end
    end
    busy_n += 32'(busy);
    done_n += 32'(done);
    chk("busy", 32'(busy), m_act);
    chk("done", 32'(done), m_done);
    chk("cur_sound", 32'(cur_sound), m_cur);
    chk("speaker", 32'(speaker), (m_act != 0 && !m) ? tone(m_cur, m_t) : 0);
  endtask

  task automatic run(input int n, input logic m);
    repeat (n) step(1'b1, 1'b0, 0, m);
  endtask

  initial begin
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    run(70, 1'b0);
    step(1'b1, 1'b1, 2, 1'b0);
    run(260, 1'b0);
    step(1'b1, 1'b1, 3, 1'b0);
    run(99, 1'b0);
    done_n = 0;
    step(1'b1, 1'b1, 0, 1'b0);
    run(70, 1'b0);
    chk("preempt_done_count", done_n, 1);
    step(1'b1, 1'b1, 0, 1'b0);
    run(62, 1'b0);
    done_n = 0;
    step(1'b1, 1'b1, 1, 1'b0);
    chk("end_restart_no_done", done_n, 0);
    run(200, 1'b0);
    busy_n = 0;
    done_n = 0;
    step(1'b1, 1'b1, 3, 1'b1);
    run(260, 1'b1);
    chk("mute_busy_cycles", busy_n, 256);
    chk("mute_done_count", done_n, 1);
    step(1'b1, 1'b1, 1, 1'b0);
    run(39, 1'b0);
    done_n = 0;
    step(1'b0, 1'b0, 0, 1'b0);
    run(10, 1'b0);
    chk("reset_no_done", done_n, 0);
    repeat (3000)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
